// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - N-channel PWM bank with per-channel prescaler, shadowed duty and soft-start ramp
module pwm_bank #(
  parameter int N_CH  = 6,
  parameter int CNT_W = 8,
  parameter int DIV_W = 3
) (
  input  logic                  clk_axi,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       ch_rst,
  input  logic [N_CH-1:0]       duty_inc,
  input  logic [N_CH-1:0]       duty_dec,
  input  logic [N_CH-1:0]       duty_load,
  input  logic [N_CH*CNT_W-1:0] duty_set,
  input  logic [N_CH*DIV_W-1:0] div,
  input  logic [N_CH-1:0]       ramp_en,
  output logic [N_CH-1:0]       pwm_out,
  output logic [N_CH*CNT_W-1:0] duty_cur,
  output logic [N_CH-1:0]       period_stb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] pre_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_tgt;
    logic [CNT_W-1:0] duty_act;
    logic             inc_q;
    logic             dec_q;
    logic             pwm_q;
    logic             stb_q;

    logic [DIV_W-1:0] div_i;
    logic [CNT_W-1:0] set_i;
    logic             tick;
    logic             wrap;
    logic             inc_edge;
    logic             dec_edge;
    logic [CNT_W-1:0] tgt_next;
    logic [CNT_W-1:0] act_next;

    assign div_i = div[i*DIV_W +: DIV_W];
    assign set_i = duty_set[i*CNT_W +: CNT_W];

    always_comb begin
      // >= rather than == so a div decrease below pre_cnt ticks at once
      tick     = pre_cnt >= div_i;
      wrap     = tick && (cnt == CNT_LAST);
      inc_edge = duty_inc[i] && !inc_q;
      dec_edge = duty_dec[i] && !dec_q;

      tgt_next = duty_tgt;
      if (duty_load[i])
        tgt_next = set_i;
      else if (inc_edge && !dec_edge && duty_tgt != CNT_MAX)
        tgt_next = duty_tgt + 1'b1;
      else if (dec_edge && !inc_edge && duty_tgt != '0)
        tgt_next = duty_tgt - 1'b1;

      act_next = duty_tgt;
      if (ramp_en[i]) begin
        if (duty_act < duty_tgt)
          act_next = duty_act + 1'b1;
        else if (duty_act > duty_tgt)
          act_next = duty_act - 1'b1;
        else
          act_next = duty_act;
      end
    end

    always_ff @(posedge clk_axi or posedge rst) begin
      if (rst) begin
        pre_cnt  <= '0;
        cnt      <= '0;
        duty_tgt <= '0;
        duty_act <= '0;
        inc_q    <= 1'b0;
        dec_q    <= 1'b0;
        pwm_q    <= 1'b0;
        stb_q    <= 1'b0;
      end else if (ch_rst[i]) begin
        pre_cnt  <= '0;
        cnt      <= '0;
        duty_tgt <= '0;
        duty_act <= '0;
        inc_q    <= 1'b0;
        dec_q    <= 1'b0;
        pwm_q    <= 1'b0;
        stb_q    <= 1'b0;
      end else begin
        inc_q    <= duty_inc[i];
        dec_q    <= duty_dec[i];
        duty_tgt <= tgt_next;
        if (!en[i]) begin
          pre_cnt  <= '0;
          cnt      <= '0;
          pwm_q    <= 1'b0;
          stb_q    <= 1'b0;
          duty_act <= ramp_en[i] ? '0 : duty_tgt;
        end else begin
          pwm_q <= cnt < duty_act;
          stb_q <= wrap;
          if (tick) begin
            pre_cnt <= '0;
            cnt     <= wrap ? '0 : cnt + 1'b1;
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
          // duty_act only moves at the period boundary to keep pulses glitch-free
          if (wrap)
            duty_act <= act_next;
        end
      end
    end

    assign pwm_out[i]                    = pwm_q;
    assign period_stb[i]                 = stb_q;
    assign duty_cur[i*CNT_W +: CNT_W]    = duty_act;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - self-checking bench for pwm_bank against a per-channel behavioural model
module tb_pwm_bank;

  localparam int NC = 6;
  localparam int CW = 8;
  localparam int DW = 3;

  logic              clk_axi = 1'b0;
  logic              rst;
  logic [NC-1:0]     en, ch_rst, duty_inc, duty_dec, duty_load, ramp_en;
  logic [NC*CW-1:0]  duty_set;
  logic [NC*DW-1:0]  div;
  logic [NC-1:0]     pwm_out, period_stb;
  logic [NC*CW-1:0]  duty_cur;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  pwm_bank #(.N_CH(NC), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk_axi(clk_axi), .rst(rst), .en(en), .ch_rst(ch_rst),
    .duty_inc(duty_inc), .duty_dec(duty_dec), .duty_load(duty_load),
    .duty_set(duty_set), .div(div), .ramp_en(ramp_en),
    .pwm_out(pwm_out), .duty_cur(duty_cur), .period_stb(period_stb)
  );

  always #5 clk_axi = ~clk_axi;

  // Model: period position runs 0..254 modulo 255, one step per prescaler tick
  typedef struct {
    int pre;
    int pos;
    int tgt;
    int act;
    bit pi;
    bit pd;
    bit pwm;
    bit stb;
  } ch_t;

  ch_t m [NC];

  function automatic ch_t step(ch_t s, bit e, bit cr, bit inc, bit dec, bit ld,
                               int setv, int d, bit rmp);
    ch_t n;
    bit  ie, de;
    n = s;
    if (cr) begin
      n = '{default: 0};
      return n;
    end
    ie = inc && !s.pi;
    de = dec && !s.pd;
    if (ld)            n.tgt = setv;
    else if (ie && !de) n.tgt = (s.tgt < 255) ? s.tgt + 1 : 255;
    else if (de && !ie) n.tgt = (s.tgt > 0) ? s.tgt - 1 : 0;
    n.pi = inc;
    n.pd = dec;
    if (!e) begin
      n.pre = 0; n.pos = 0; n.pwm = 0; n.stb = 0;
      n.act = rmp ? 0 : s.tgt;
    end else begin
      n.pwm = (s.pos < s.act);
      n.stb = 0;
      if (s.pre >= d) begin
        n.pre = 0;
        n.pos = (s.pos + 1) % 255;
        if (s.pos == 254) begin
          n.stb = 1;
          if (!rmp)                n.act = s.tgt;
          else if (s.act < s.tgt)  n.act = s.act + 1;
          else if (s.act > s.tgt)  n.act = s.act - 1;
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) m[c] <= '{default: 0};
    end else begin
      for (int c = 0; c < NC; c++)
        m[c] <= step(m[c], en[c], ch_rst[c], duty_inc[c], duty_dec[c], duty_load[c],
                     int'(duty_set[c*CW +: CW]), int'(div[c*DW +: DW]), ramp_en[c]);
    end
  end

  logic [NC-1:0]    e_pwm, e_stb;
  logic [NC*CW-1:0] e_cur;
  always_comb begin
    e_pwm = '0;
    e_stb = '0;
    e_cur = '0;
    for (int c = 0; c < NC; c++) begin
      e_pwm[c]         = m[c].pwm;
      e_stb[c]         = m[c].stb;
      e_cur[c*CW +: CW] = CW'(m[c].act);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_axi) begin
    if (mon_on) begin
      chk("model_pwm_out", pwm_out, e_pwm);
      chk("model_period_stb", period_stb, e_stb);
      chk("model_duty_cur", duty_cur, e_cur);
    end
  end

  function automatic logic [7:0] cur(input int ch);
    return duty_cur[ch*CW +: CW];
  endfunction

  task automatic load(input int ch, input logic [7:0] v);
    duty_set[ch*CW +: CW] = v;
    duty_load[ch] = 1'b1;
    @(negedge clk_axi);
    duty_load[ch] = 1'b0;
  endtask

  task automatic pulse(input int ch, input bit inc, input bit dec, input int n);
    repeat (n) begin
      duty_inc[ch] = inc;
      duty_dec[ch] = dec;
      @(negedge clk_axi);
      duty_inc[ch] = 1'b0;
      duty_dec[ch] = 1'b0;
      @(negedge clk_axi);
    end
  endtask

  task automatic wait_stb(input int ch);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_axi);
      if (period_stb[ch]) return;
    end
    chk("wait_stb_timeout", 1, 0);
  endtask

  // Counts cycles and high cycles up to and including the next strobe.
  // kind 1: load val into ch; kind 2: set ch div to val; kind 3: pulse ch_rst on channel val
  task automatic measure(input int ch, output int hi, output int cyc,
                         input int at, input int kind, input int val);
    hi = 0;
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_axi);
      cyc++;
      hi += int'(pwm_out[ch]);
      if (i == at) begin
        if (kind == 1) begin duty_set[ch*CW +: CW] = 8'(val); duty_load[ch] = 1'b1; end
        if (kind == 2) div[ch*DW +: DW] = 3'(val);
        if (kind == 3) ch_rst[val] = 1'b1;
      end
      if (i == at + 1) begin
        duty_load = '0;
        ch_rst = '0;
      end
      if (period_stb[ch]) return;
    end
    chk("measure_timeout", 1, 0);
  endtask

  int hi, cyc;

  initial begin
    rst = 1'b1;
    en = '0; ch_rst = '0; duty_inc = '0; duty_dec = '0; duty_load = '0; ramp_en = '0;
    duty_set = '0; div = '0;
    repeat (3) @(negedge clk_axi);
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_duty_cur", duty_cur, 0);
    chk("reset_period_stb", period_stb, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // ch0 basic duty 64, shadow update only at wrap
    en[0] = 1'b1;
    load(0, 8'd64);
    repeat (5) @(negedge clk_axi);
    chk("ch0_cur_before_wrap", cur(0), 0);
    wait_stb(0);
    chk("ch0_cur_after_wrap", cur(0), 64);
    measure(0, hi, cyc, -1, 0, 0);
    chk("ch0_high_64", hi, 64);
    chk("ch0_period_255", cyc, 255);

    // mid-period reload leaves the running period alone
    measure(0, hi, cyc, 100, 1, 200);
    chk("ch0_reload_cur_period", hi, 64);
    measure(0, hi, cyc, -1, 0, 0);
    chk("ch0_reload_next_period", hi, 200);

    // ch1 saturating inc/dec and simultaneous edges
    en[1] = 1'b1;
    load(1, 8'd254);
    pulse(1, 1'b1, 1'b0, 3);
    wait_stb(1); wait_stb(1);
    chk("ch1_inc_sat", cur(1), 255);
    measure(1, hi, cyc, -1, 0, 0);
    chk("ch1_const_high", hi, 255);
    load(1, 8'd1);
    pulse(1, 1'b0, 1'b1, 3);
    wait_stb(1); wait_stb(1);
    chk("ch1_dec_sat", cur(1), 0);
    measure(1, hi, cyc, -1, 0, 0);
    chk("ch1_const_low", hi, 0);
    load(1, 8'd100);
    pulse(1, 1'b1, 1'b1, 1);
    wait_stb(1); wait_stb(1);
    chk("ch1_inc_dec_together", cur(1), 100);

    // ch2 soft start
    ramp_en[2] = 1'b1;
    load(2, 8'd4);
    en[2] = 1'b1;
    wait_stb(2);
    chk("ch2_ramp_cur1", cur(2), 1);
    for (int k = 2; k <= 4; k++) begin
      measure(2, hi, cyc, -1, 0, 0);
      chk("ch2_ramp_high", hi, k - 1);
      chk("ch2_ramp_cur", cur(2), k);
    end
    measure(2, hi, cyc, -1, 0, 0);
    chk("ch2_ramp_high4", hi, 4);

    // ch3 prescaler, live div change, soft reset isolation
    div[3*DW +: DW] = 3'd3;
    load(3, 8'd64);
    en[3] = 1'b1;
    wait_stb(3); wait_stb(3);
    measure(3, hi, cyc, -1, 0, 0);
    chk("ch3_div3_period", cyc, 1020);
    chk("ch3_div3_high", hi, 256);
    measure(3, hi, cyc, 1, 2, 0);
    chk("ch3_div_switch_period", cyc, 257);
    chk("ch3_div_switch_high", hi, 66);
    measure(3, hi, cyc, -1, 0, 0);
    chk("ch3_div0_period", cyc, 255);
    wait_stb(0);
    measure(0, hi, cyc, 50, 3, 3);
    chk("ch0_unaffected_high", hi, 200);
    chk("ch0_unaffected_period", cyc, 255);
    chk("ch3_cleared_cur", cur(3), 0);
    chk("ch3_cleared_pwm", pwm_out[3], 0);

    // asynchronous reset between clock edges
    repeat (3) @(negedge clk_axi);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm_out", pwm_out, 0);
    chk("async_rst_duty_cur", duty_cur, 0);
    chk("async_rst_period_stb", period_stb, 0);
    repeat (2) @(negedge clk_axi);
    rst = 1'b0;
    repeat (3) @(negedge clk_axi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
